// File: rtl/ov7670_color_tracker_if.sv
// rtl/ov7670_color_tracker_if.sv - pixel stream in, per-frame tracking results out
interface ov7670_color_tracker_if;
  logic        DE;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic [3:0]  r_port;
  logic [3:0]  g_port;
  logic [3:0]  b_port;
  logic        done;
  logic        found;
  logic [18:0] pix_count;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [9:0]  x_min;
  logic [9:0]  x_max;
  logic [9:0]  y_min;
  logic [9:0]  y_max;
  logic        busy;

  // Tracker side: consumes pixels, produces results
  modport slave (
    input  DE, x_pixel, y_pixel, r_port, g_port, b_port,
    output done, found, pix_count, cx, cy, x_min, x_max, y_min, y_max, busy
  );

  // Video source / result consumer side
  modport master (
    output DE, x_pixel, y_pixel, r_port, g_port, b_port,
    input  done, found, pix_count, cx, cy, x_min, x_max, y_min, y_max, busy
  );
endinterface

// File: rtl/ov7670_color_tracker.sv
// rtl/ov7670_color_tracker.sv - colour-window blob tracker with per-frame centroid
module ov7670_color_tracker #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [3:0]  R_MIN     = 4'd10,
  parameter logic [3:0]  G_MAX     = 4'd5,
  parameter logic [3:0]  B_MAX     = 4'd5,
  parameter logic [18:0] MIN_COUNT = 19'd64
) (
  input  logic                    clk,
  input  logic                    reset,
  ov7670_color_tracker_if.slave   bus
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
  state_t state, state_nxt;

  logic        m1, f1, l1;
  logic [9:0]  x1, y1;
  logic [18:0] cnt, cnt_n, cnt_snap;
  logic [27:0] sx, sy, sx_n, sy_n, sx_snap, sy_snap;
  logic [9:0]  bx0, bx1, by0, by1, bx0_n, bx1_n, by0_n, by1_n;
  logic [9:0]  bx0_snap, bx1_snap, by0_snap, by1_snap;
  logic        armed, start, take;
  logic [27:0] dvd;
  logic [18:0] rem, rem_nxt, diff;
  logic [19:0] rem_sh;
  logic        q_bit;
  logic [9:0]  quot, qx;
  logic [4:0]  bit_cnt;
  logic        done_q, found_q;
  logic [18:0] pix_q;
  logic [9:0]  cx_q, cy_q, xmin_q, xmax_q, ymin_q, ymax_q;

  // Stage 1: classify the pixel and flag frame boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      m1 <= 1'b0; f1 <= 1'b0; l1 <= 1'b0; x1 <= '0; y1 <= '0;
    end else begin
      m1 <= bus.DE && (bus.r_port >= R_MIN) && (bus.g_port <= G_MAX) && (bus.b_port <= B_MAX);
      f1 <= bus.DE && (bus.x_pixel == 10'd0) && (bus.y_pixel == 10'd0);
      l1 <= bus.DE && (bus.x_pixel == X_LAST) && (bus.y_pixel == Y_LAST);
      x1 <= bus.x_pixel;
      y1 <= bus.y_pixel;
    end
  end

  // Stage 2 next values: the first pixel restarts the frame from itself alone
  always_comb begin
    cnt_n = cnt; sx_n = sx; sy_n = sy;
    bx0_n = bx0; bx1_n = bx1; by0_n = by0; by1_n = by1;
    if (f1) begin
      if (m1) begin
        cnt_n = 19'd1; sx_n = {18'd0, x1}; sy_n = {18'd0, y1};
        bx0_n = x1; bx1_n = x1; by0_n = y1; by1_n = y1;
      end else begin
        cnt_n = '0; sx_n = '0; sy_n = '0;
        bx0_n = 10'd1023; bx1_n = '0; by0_n = 10'd1023; by1_n = '0;
      end
    end else if (m1) begin
      cnt_n = cnt + 19'd1;
      sx_n  = sx + {18'd0, x1};
      sy_n  = sy + {18'd0, y1};
      if (x1 < bx0) bx0_n = x1;
      if (x1 > bx1) bx1_n = x1;
      if (y1 < by0) by0_n = y1;
      if (y1 > by1) by1_n = y1;
    end
  end

  // A frame end is accepted only once armed and while the divider is free
  assign take = l1 && armed && (state == IDLE) && !start;

  // Stage 2 accumulators, frame snapshot and divider start request
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0; sx <= '0; sy <= '0; bx0 <= '0; bx1 <= '0; by0 <= '0; by1 <= '0;
      armed <= 1'b0; start <= 1'b0;
      cnt_snap <= '0; sx_snap <= '0; sy_snap <= '0;
      bx0_snap <= '0; bx1_snap <= '0; by0_snap <= '0; by1_snap <= '0;
    end else begin
      cnt <= cnt_n; sx <= sx_n; sy <= sy_n;
      bx0 <= bx0_n; bx1 <= bx1_n; by0 <= by0_n; by1 <= by1_n;
      if (f1) armed <= 1'b1;
      start <= take;
      if (take) begin
        cnt_snap <= cnt_n; sx_snap <= sx_n; sy_snap <= sy_n;
        bx0_snap <= bx0_n; bx1_snap <= bx1_n; by0_snap <= by0_n; by1_snap <= by1_n;
      end
    end
  end

  // One restoring-division step; rem stays below the divisor so 19 bits suffice
  always_comb begin
    rem_sh  = {rem, dvd[27]};
    q_bit   = (rem_sh >= {1'b0, cnt_snap});
    diff    = rem_sh[18:0] - cnt_snap;
    rem_nxt = q_bit ? diff : rem_sh[18:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: two fixed-length divides then publish
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV_X;
      DIV_X:   if (bit_cnt == 5'd27) state_nxt = DIV_Y;
      DIV_Y:   if (bit_cnt == 5'd27) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd <= '0; rem <= '0; quot <= '0; qx <= '0; bit_cnt <= '0;
      done_q <= 1'b0; found_q <= 1'b0; pix_q <= '0;
      cx_q <= '0; cy_q <= '0; xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd <= sx_snap; rem <= '0; quot <= '0; bit_cnt <= '0;
          end
        end
        DIV_X, DIV_Y: begin
          rem     <= rem_nxt;
          quot    <= {quot[8:0], q_bit};
          dvd     <= {dvd[26:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (state == DIV_X && bit_cnt == 5'd27) begin
            qx <= {quot[8:0], q_bit};
            dvd <= sy_snap; rem <= '0; quot <= '0; bit_cnt <= '0;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          pix_q  <= cnt_snap;
          if (cnt_snap == 19'd0) begin
            found_q <= 1'b0; cx_q <= '0; cy_q <= '0;
            xmin_q <= '0; xmax_q <= '0; ymin_q <= '0; ymax_q <= '0;
          end else begin
            found_q <= (cnt_snap >= MIN_COUNT);
            cx_q <= qx; cy_q <= quot;
            xmin_q <= bx0_snap; xmax_q <= bx1_snap; ymin_q <= by0_snap; ymax_q <= by1_snap;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.pix_count = pix_q;
  assign bus.cx        = cx_q;
  assign bus.cy        = cy_q;
  assign bus.x_min     = xmin_q;
  assign bus.x_max     = xmax_q;
  assign bus.y_min     = ymin_q;
  assign bus.y_max     = ymax_q;
  assign bus.busy      = (state == DIV_X) || (state == DIV_Y);

endmodule

// File: tb/tb_ov7670_color_tracker.sv
// tb/tb_ov7670_color_tracker.sv - frame-level scoreboard bench for the colour tracker
module tb_ov7670_color_tracker;

  localparam int H = 32;
  localparam int V = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ov7670_color_tracker_if bus();

  ov7670_color_tracker #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int rx0, rx1, ry0, ry1;
    int cnt, cx, cy, xmin, xmax, ymin, ymax, found;
  } case_t;

  typedef struct {
    int idx;
    int exp_cyc;
  } sb_t;

  case_t tbl[7];
  sb_t   sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, {bus.done, bus.found, bus.busy, bus.pix_count, bus.cx, bus.cy,
                            bus.x_min, bus.x_max, bus.y_min, bus.y_max}, 0);
  endtask

  // Result monitor: every done must match the oldest expected frame at the exact cycle
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.exp_cyc);
        check("pix_count", bus.pix_count, tbl[e.idx].cnt);
        check("cx", bus.cx, tbl[e.idx].cx);
        check("cy", bus.cy, tbl[e.idx].cy);
        check("x_min", bus.x_min, tbl[e.idx].xmin);
        check("x_max", bus.x_max, tbl[e.idx].xmax);
        check("y_min", bus.y_min, tbl[e.idx].ymin);
        check("y_max", bus.y_max, tbl[e.idx].ymax);
        check("found", bus.found, tbl[e.idx].found);
      end
    end
  end

  task automatic set_px(input bit de, input int x, input int y, input int r, input int g, input int b);
    bus.DE = de;
    bus.x_pixel = 10'(x);
    bus.y_pixel = 10'(y);
    bus.r_port = 4'(r);
    bus.g_port = 4'(g);
    bus.b_port = 4'(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_px(1'b0, 0, 0, 15, 0, 0);
    end
  endtask

  // One frame with per-line blanking; boundary colours exercise each threshold
  task automatic drive_frame(input int idx, input bit push, input int rst_line);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        @(negedge clk);
        reset = (y == rst_line && x == 0);
        if (x >= tbl[idx].rx0 && x <= tbl[idx].rx1 && y >= tbl[idx].ry0 && y <= tbl[idx].ry1) begin
          if (((x + y) % 2) == 0) set_px(1'b1, x, y, 15, 0, 0);
          else                    set_px(1'b1, x, y, 10, 5, 5);
        end else begin
          case ((x + y) % 4)
            0:       set_px(1'b1, x, y, 0, 0, 0);
            1:       set_px(1'b1, x, y, 9, 0, 0);
            2:       set_px(1'b1, x, y, 15, 6, 0);
            default: set_px(1'b1, x, y, 15, 0, 6);
          endcase
        end
        if (x == H - 1 && y == V - 1 && push) begin
          sb_t e;
          e.idx = idx;
          e.exp_cyc = cyc + 60;
          sb.push_back(e);
        end
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        reset = 1'b0;
        set_px(1'b0, H + i, y, 15, 0, 0);
      end
    end
    idle(4);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    //         rx0 rx1 ry0 ry1  cnt  cx  cy xmin xmax ymin ymax found
    tbl[0] = '{1,  0,  1,  0,    0,  0,  0,  0,   0,   0,   0,   0};
    tbl[1] = '{10, 17, 5,  12,   64, 13, 8,  10,  17,  5,   12,  1};
    tbl[2] = '{31, 31, 23, 23,   1,  31, 23, 31,  31,  23,  23,  0};
    tbl[3] = '{0,  31, 0,  23,   768,15, 11, 0,   31,  0,   23,  1};
    tbl[4] = '{20, 27, 10, 17,   64, 23, 13, 20,  27,  10,  17,  1};
    tbl[5] = '{3,  11, 2,  8,    63, 7,  5,  3,   11,  2,   8,   0};
    tbl[6] = '{0,  0,  0,  0,    1,  0,  0,  0,   0,   0,   0,   0};

    set_px(1'b0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Back-to-back frames: each division overlaps the start of the next frame
    for (int i = 0; i < 7; i++) drive_frame(i, 1'b1, -1);
    wait_drain("drain_table");

    idle(50);
    check("hold_pix_count", bus.pix_count, tbl[6].cnt);
    check("hold_found", bus.found, tbl[6].found);

    // Reset part-way through a frame: that frame must never report
    drive_frame(1, 1'b0, V / 2);
    idle(80);
    check_all_zero("midframe_reset");
    drive_frame(4, 1'b1, -1);
    wait_drain("drain_after_midframe");

    // Reset during division: everything clears on the next cycle, no done follows
    drive_frame(3, 1'b1, -1);
    check("busy_during_div", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("busy_reset");
    sb.delete();
    idle(100);
    check("no_late_done", bus.done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
